// File: rtl/frame_assembler_fifo.sv
`default_nettype none
// ============================================================================
// Module      : frame_assembler_fifo
// Description : Collects the de-stuffed bits of each received CAN frame
//               between SOF and the frame controller's end-of-frame mark and
//               commits every completed frame, together with its stored-bit
//               count and a truncation flag, into a DEPTH-entry FIFO drained
//               through a valid/ready handshake. Erroneous or restarted
//               frames are discarded (aborted pulse); completed frames that
//               find the FIFO full are dropped (overrun pulse).
//
// Optional    : FRAME_TIMESTAMP_EN - adds a 16-bit free-running sample
//               counter, captures it at each SOF and stores it per entry;
//               the head entry's value appears on the extra port rdStamp.
//
// Ports       : samplePoint  clock, one rising edge per sampled CAN bit
//               reset        synchronous active-high reset
//               canRX        sampled bus bit
//               isStart      current bit is SOF
//               isStuff      current bit is a stuff bit (not stored)
//               isError      abort the frame in progress
//               frameDone    current bit is the last bit of the frame
//               rdReady      consumer accepts the head entry
//               rdValid      FIFO not empty
//               rdFrame      head frame, latest bit at LSB
//               rdSize       head frame stored-bit count
//               rdTrunc      head frame exceeded MAX_BITS
//               fillLevel    occupied entries
//               overrun      one-cycle pulse, completed frame dropped
//               aborted      one-cycle pulse, frame in progress discarded
//               rdStamp      head entry SOF timestamp (FRAME_TIMESTAMP_EN)
//
// Revision    : 1.0 - initial release
// ============================================================================
module frame_assembler_fifo #(
    parameter int    MAX_BITS = 590,
    parameter int    DEPTH    = 4,
    localparam int   SW       = $clog2(MAX_BITS + 1),
    localparam int   FW       = $clog2(DEPTH + 1)
) (
    input  logic                samplePoint,
    input  logic                reset,
    input  logic                canRX,
    input  logic                isStart,
    input  logic                isStuff,
    input  logic                isError,
    input  logic                frameDone,
    input  logic                rdReady,
    output logic                rdValid,
    output logic [MAX_BITS-1:0] rdFrame,
    output logic [SW-1:0]       rdSize,
    output logic                rdTrunc,
    output logic [FW-1:0]       fillLevel,
    output logic                overrun,
    output logic                aborted
`ifdef FRAME_TIMESTAMP_EN
    ,
    output logic [15:0]         rdStamp
`endif
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [SW-1:0] C_MAX   = SW'(MAX_BITS);
    localparam logic [FW-1:0] C_DEPTH = FW'(DEPTH);

    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_RECV = 1'b1;

    // ------------------------------------------------------------------
    // Assembly state
    // ------------------------------------------------------------------
    logic [0:0]          state_q, state_d;
    logic [MAX_BITS-1:0] frame_q, frame_d;
    logic [SW-1:0]       count_q, count_d;
    logic                trunc_q, trunc_d;

    // FSM output decodes
    logic w_load;    // start a new frame on this bit
    logic w_abort;   // discard the frame in progress
    logic w_commit;  // completed frame offered to the FIFO

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [MAX_BITS-1:0] mem_frame_q [DEPTH];
    logic [SW-1:0]       mem_size_q  [DEPTH];
    logic                mem_trunc_q [DEPTH];
    logic [AW-1:0]       wr_q, rd_q;
    logic [FW-1:0]       fill_q;
    logic                overrun_q, aborted_q;

    logic w_full, w_pop, w_push;

`ifdef FRAME_TIMESTAMP_EN
    logic [15:0] stamp_q;
    logic [15:0] sof_stamp_q;
    logic [15:0] mem_stamp_q [DEPTH];
`endif

    // ------------------------------------------------------------------
    // FSM: state register (with assembly datapath)
    // ------------------------------------------------------------------
    always_ff @(posedge samplePoint) begin
        if (reset) begin
            state_q <= C_IDLE;
            frame_q <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. frame_d/count_d/trunc_d already include the
    // current bit, so a commit stores them directly.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        count_d = count_q;
        trunc_d = trunc_q;
        if (w_load) begin
            state_d = C_RECV;
            frame_d = '0;
            frame_d[0] = canRX;
            count_d = SW'(1);
            trunc_d = 1'b0;
        end else if (state_q == C_RECV) begin
            if (isError) begin
                state_d = C_IDLE;
            end else begin
                if (!isStuff) begin
                    if (count_q < C_MAX) begin
                        frame_d    = frame_q << 1;
                        frame_d[0] = canRX;
                        count_d    = count_q + SW'(1);
                    end else begin
                        trunc_d = 1'b1;
                    end
                end
                if (frameDone) begin
                    state_d = C_IDLE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode. isError outranks isStart, which outranks
    // frameDone.
    // ------------------------------------------------------------------
    always_comb begin
        w_load   = 1'b0;
        w_abort  = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            C_IDLE: begin
                w_load = isStart;
            end
            C_RECV: begin
                if (isError) begin
                    w_abort = 1'b1;
                end else if (isStart) begin
                    w_abort = 1'b1;
                    w_load  = 1'b1;
                end else begin
                    w_commit = frameDone;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control. A full FIFO still accepts a frame when the head is
    // popped on the same edge.
    // ------------------------------------------------------------------
    assign w_full = (fill_q == C_DEPTH);
    assign w_pop  = (fill_q != '0) && rdReady;
    assign w_push = w_commit && (!w_full || w_pop);

    always_ff @(posedge samplePoint) begin
        if (reset) begin
            wr_q      <= '0;
            rd_q      <= '0;
            fill_q    <= '0;
            overrun_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            overrun_q <= w_commit && !w_push;
            aborted_q <= w_abort;
            if (w_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (w_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   fill_q <= fill_q + FW'(1);
                2'b01:   fill_q <= fill_q - FW'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Entry storage needs no reset: the read port is gated by rdValid.
    always_ff @(posedge samplePoint) begin
        if (w_push) begin
            mem_frame_q[wr_q] <= frame_d;
            mem_size_q[wr_q]  <= count_d;
            mem_trunc_q[wr_q] <= trunc_d;
        end
    end

`ifdef FRAME_TIMESTAMP_EN
    // Free-running sample counter; the SOF value follows the frame.
    always_ff @(posedge samplePoint) begin
        if (reset) begin
            stamp_q     <= '0;
            sof_stamp_q <= '0;
        end else begin
            stamp_q <= stamp_q + 16'd1;
            if (w_load) begin
                sof_stamp_q <= stamp_q;
            end
        end
    end

    always_ff @(posedge samplePoint) begin
        if (w_push) begin
            mem_stamp_q[wr_q] <= sof_stamp_q;
        end
    end

    assign rdStamp = rdValid ? mem_stamp_q[rd_q] : 16'd0;
`endif

    // ------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------
    assign rdValid   = (fill_q != '0);
    assign rdFrame   = rdValid ? mem_frame_q[rd_q] : '0;
    assign rdSize    = rdValid ? mem_size_q[rd_q]  : '0;
    assign rdTrunc   = rdValid ? mem_trunc_q[rd_q] : 1'b0;
    assign fillLevel = fill_q;
    assign overrun   = overrun_q;
    assign aborted   = aborted_q;

endmodule
`default_nettype wire

// File: doc/frame_assembler_fifo.md
# frame_assembler_fifo

Parametrised successor to the receive-side frame storage path. Collects the de-stuffed bits of each CAN frame between start-of-frame and the frame controller's end-of-frame indication. Commits every completed frame, with its bit count and a truncation flag, into a DEPTH-entry FIFO. A consumer drains the FIFO through a valid/ready handshake, so several back-to-back frames survive a slow reader. Erroneous frames are discarded, and drops on a full FIFO are reported.

## Interface
- MAX_BITS, 590: assembly register width; 590 covers a CAN FD 64-byte frame.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- SW, $clog2(MAX_BITS+1): width of size fields (derived localparam).
- samplePoint  input  1  clock; one rising edge per sampled CAN bit.
- reset  input  1  synchronous, active-high.
- canRX  input  1  sampled bus bit for this edge.
- isStart  input  1  current bit is SOF.
- isStuff  input  1  current bit is a stuff bit; not stored.
- isError  input  1  error detected; abort current frame.
- frameDone  input  1  current bit is the last bit of the frame.
- rdReady  input  1  consumer accepts head entry.
- rdValid  output  1  FIFO not empty.
- rdFrame  output  MAX_BITS  head frame; latest bit at LSB, unused upper bits 0.
- rdSize  output  SW  head frame stored-bit count.
- rdTrunc  output  1  head frame exceeded MAX_BITS.
- fillLevel  output  $clog2(DEPTH+1)  occupied entries.
- overrun  output  1  one-cycle pulse; a completed frame was dropped because the FIFO was full.
- aborted  output  1  one-cycle pulse; a frame in progress was discarded.

## Operation
- Assembly FSM states:
  - IDLE: isStart=1 → RECEIVING. Assembly register is loaded with {0…0, canRX}, count=1, trunc=0. Other inputs are ignored.
  - RECEIVING, non-stuff bit (isStuff=0):
    - count<MAX_BITS: shift left, canRX enters the LSB, count+1.
    - count==MAX_BITS: bit is dropped, trunc=1.
  - RECEIVING, stuff bit: no change.
- Priority in RECEIVING, highest first:
  1. isError: discard, aborted=1, → IDLE.
  2. isStart: discard, aborted=1, restart as for IDLE→RECEIVING.
  3. frameDone: current bit is processed as above, then commit, → IDLE.
- Commit writes {register incl. current bit, count, trunc} to the tail.
  - Commit succeeds when not full, or when full and a pop occurs in the same cycle.
  - Otherwise the frame is dropped and overrun=1.
- Pop: rdValid && rdReady advances the head. Simultaneous push and pop leaves fillLevel unchanged.
- Read outputs are combinational from the head entry; they are don't-care when rdValid=0.
- Pointers are log2(DEPTH)-bit and wrap naturally; an extra occupancy counter distinguishes full from empty.

## Timing
- Reset: FSM→IDLE; pointers, fillLevel, count and trunc cleared; rdValid=0, overrun=0, aborted=0, rdFrame=0, rdSize=0, rdTrunc=0. Reset mid-frame discards the frame without asserting aborted.
- A commit on edge N gives rdValid=1 and the new head data after edge N (visible from cycle N+1). Minimum latency from the last bit to availability is one edge.
- overrun and aborted are high for exactly the one cycle after the triggering edge.
- Back-to-back frames are supported: frameDone on edge N and isStart on edge N+1.
- rdReady while rdValid=0 is ignored.

## Configuration
- FRAME_TIMESTAMP_EN defined:
  - A 16-bit free-running counter increments on every samplePoint edge and wraps; it resets to 0.
  - Its value at the SOF edge is captured and stored per entry.
  - Extra output port rdStamp (16 bits) carries the head entry's timestamp.
- FRAME_TIMESTAMP_EN undefined: no counter, no rdStamp port, no per-entry storage.

## Test plan
- Single frame: isStart on the first bit, then 18 further bits (2 flagged isStuff), frameDone on the last → rdValid=1 next cycle, rdSize=17, rdTrunc=0, rdFrame LSBs equal the 17 non-stuff bits.
- Fill: 4 frames, no reads, DEPTH=4 → fillLevel=4. A 5th frameDone → overrun pulses once, fillLevel stays 4, the head is still frame 1. The 5th frame plus a same-edge pop → accepted, fillLevel stays 4.
- Truncation: MAX_BITS=16, 20 non-stuff bits → rdSize=16, rdTrunc=1, rdFrame holds the first 16 bits.
- Error: isError at bit 10 → aborted pulses, no FIFO write. The next frame is stored normally.
- Restart: isStart mid-frame → aborted pulses, the new frame has count=1 from the restart bit.
- Wrap and timestamp (macro on): 10 frames written and read alternately → order preserved across pointer wrap. rdStamp equals the counter value at each SOF.
